// File: rtl/ram_pkg.sv
// Shared types and constants for the ram_controller front-end arbiter.
package ram_pkg;

  localparam int ADDR_W_DEF   = 23;
  localparam int DATA_W_DEF   = 16;

  localparam logic RW_READ    = 1'b0;
  localparam logic RW_WRITE   = 1'b1;

  // Cycles after mem during which ready must drop before the op is assumed done.
  localparam int BUSY_TIMEOUT = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESPOND
  } state_t;

endpackage

// File: rtl/rr_grant2.sv
// Two-requester round-robin pick: on contention the requester that was not
// granted last wins.
module rr_grant2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       valid
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

  assign valid = |req;

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter between two masters in front of ram_controller:
// registers the winning request, issues one mem pulse, returns ack/rdata.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_rw,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_rw,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem,
  output logic              rw,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  input  logic              ready
);

  localparam logic [2:0] BUSY_LAST = 3'(BUSY_TIMEOUT - 1);

  state_t     state, state_n;
  logic       last_grant;
  logic       grant_id;
  logic [2:0] busy_cnt;
  logic [1:0] gnt;
  logic       gnt_valid;
  logic       win;
  logic       latch;
  logic       capture;

  rr_grant2 u_pick (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant),
    .grant      (gnt),
    .valid      (gnt_valid)
  );

  assign win = gnt[1] && !gnt[0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    latch   = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (ready && gnt_valid) begin
          latch   = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE:     state_n = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!ready)                       state_n = WAIT_DONE;
        else if (busy_cnt == BUSY_LAST)   state_n = RESPOND;
      end
      WAIT_DONE: begin
        if (ready) begin
          capture = (rw == RW_READ);
          state_n = RESPOND;
        end
      end
      RESPOND:   state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // mem and ack are registered from the next state so each is high exactly
  // during the ISSUE / RESPOND cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem        <= 1'b0;
      rw         <= RW_READ;
      address    <= '0;
      data_in    <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      busy_cnt   <= '0;
    end else begin
      mem      <= (state_n == ISSUE);
      m0_ack   <= (state_n == RESPOND) && (grant_id == 1'b0);
      m1_ack   <= (state_n == RESPOND) && (grant_id == 1'b1);
      busy_cnt <= (state == WAIT_BUSY) ? busy_cnt + 3'd1 : '0;
      if (latch) begin
        rw         <= win ? m1_rw    : m0_rw;
        address    <= win ? m1_addr  : m0_addr;
        data_in    <= win ? m1_wdata : m0_wdata;
        grant_id   <= win;
        last_grant <= win;
      end
      if (capture) begin
        if (grant_id) m1_rdata <= data_out;
        else          m0_rdata <= data_out;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed + randomized bench for ram_arbiter with a behavioural RAM and
// arbitration reference model.
module tb_ram_arbiter;

  localparam int AW       = 23;
  localparam int DW       = 16;
  localparam int BUSY_LEN = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_rw, m1_req, m1_rw;
  logic [AW-1:0] m0_addr, m1_addr, address;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, data_in, data_out;
  logic          m0_ack, m1_ack, mem, rw, ready;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem(mem), .rw(rw), .address(address), .data_in(data_in),
    .data_out(data_out), .ready(ready)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural ram_controller: ready drops one cycle after mem, stays low
  // BUSY_LEN cycles, then returns with read data.
  logic          rdy_model;
  bit            force_low, never_drop;
  int            mem_cnt = 0;
  logic [DW-1:0] mem_model [int];
  bit            pend_drop, busy;
  int            bcnt;
  logic [DW-1:0] rd_hold;

  assign ready = rdy_model && !force_low;

  function automatic logic [DW-1:0] rd_ref(input logic [AW-1:0] a);
    if (mem_model.exists(int'(a))) return mem_model[int'(a)];
    return a[DW-1:0] ^ 16'h5A5A;
  endfunction

  initial begin
    rdy_model = 1'b1; data_out = '0; pend_drop = 0; busy = 0; bcnt = 0; rd_hold = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        rdy_model = 1'b1; pend_drop = 0; busy = 0;
      end else begin
        if (pend_drop) begin
          rdy_model = 1'b0; pend_drop = 0; busy = 1; bcnt = BUSY_LEN - 1;
        end else if (busy) begin
          if (bcnt == 0) begin
            rdy_model = 1'b1; data_out = rd_hold; busy = 0;
          end else bcnt--;
        end
        if (mem) begin
          mem_cnt++;
          if (rw) mem_model[int'(address)] = data_in;
          else    rd_hold = rd_ref(address);
          if (!never_drop) pend_drop = 1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  // Master-side stimulus and reference state
  bit            rq [2];
  logic          r_w [2];
  logic [AW-1:0] a [2];
  logic [DW-1:0] wd [2];
  logic [DW-1:0] exp_rd [2];
  int            exp_last;
  logic          rdy_d1 = 1'b1, rdy_d2 = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    rdy_d2 = rdy_d1;
    rdy_d1 = ready;
    @(posedge clk); #2;
  endtask

  task automatic drive();
    m0_req = rq[0]; m0_rw = r_w[0]; m0_addr = a[0]; m0_wdata = wd[0];
    m1_req = rq[1]; m1_rw = r_w[1]; m1_addr = a[1]; m1_wdata = wd[1];
  endtask

  task automatic rand_fields(input int m);
    r_w[m] = 1'($urandom_range(0, 1));
    a[m]   = AW'($urandom);
    wd[m]  = DW'($urandom);
  endtask

  // Serve one operation: predict the winner, check the mem pulse and the ack.
  task automatic serve_one(input bit keep, input int ack_limit, output int m);
    logic [AW-1:0] ea; logic [DW-1:0] ed, er; logic erw;
    int t, lat, mc0;
    m   = (rq[0] && rq[1]) ? ((exp_last == 1) ? 0 : 1) : (rq[0] ? 0 : 1);
    ea  = a[m]; ed = wd[m]; erw = r_w[m];
    er  = (erw || never_drop) ? exp_rd[m] : rd_ref(ea);
    mc0 = mem_cnt;
    t = 0;
    while (!mem && t < 40) begin step(); t++; end
    chk("mem_pulse", 32'(mem), 1);
    chk("rw", 32'(rw), 32'(erw));
    chk("address", 32'(address), 32'(ea));
    chk("data_in", 32'(data_in), 32'(ed));
    exp_last = m;
    lat = 0;
    while (!(m0_ack || m1_ack) && lat < 40) begin step(); lat++; end
    chk("ack_m0", 32'(m0_ack), 32'(m == 0));
    chk("ack_m1", 32'(m1_ack), 32'(m == 1));
    chk("ack_latency", 32'(lat <= ack_limit), 1);
    chk("single_mem", 32'(mem_cnt - mc0), 1);
    if (!never_drop) chk("ack_after_ready", {30'd0, rdy_d2, rdy_d1}, 32'b01);
    chk("rdata", 32'(m ? m1_rdata : m0_rdata), 32'(er));
    exp_rd[m] = er;
    if (keep) rand_fields(m);
    else      rq[m] = 0;
    drive();
    step();
    chk("ack_one_cycle", {30'd0, m0_ack, m1_ack}, 0);
    chk("rdata_hold", 32'(m ? m1_rdata : m0_rdata), 32'(er));
  endtask

  initial begin
    int m, t, mc;
    bit seen_ack;
    reset = 1'b1; force_low = 0; never_drop = 0; exp_last = 1;
    for (int i = 0; i < 2; i++) begin
      rq[i] = 0; r_w[i] = 0; a[i] = '0; wd[i] = '0; exp_rd[i] = '0;
    end
    drive();
    repeat (2) step();
    chk("reset_ctrl", {29'd0, mem, rw, m0_ack | m1_ack}, 0);
    chk("reset_address", 32'(address), 0);
    chk("reset_data_in", 32'(data_in), 0);
    chk("reset_rdata", {m0_rdata, m1_rdata}, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_quiet", {3'd0, mem, m0_ack, m1_ack, address}, 0);
    end

    // Single write from master 0
    rq[0] = 1; r_w[0] = 1; a[0] = 23'h0FFFFF; wd[0] = 16'hFFFF; drive();
    serve_one(0, 8, m);

    // Single read from master 1
    mem_model[32'h10] = 16'hA5C3;
    rq[1] = 1; r_w[1] = 0; a[1] = 23'h000010; wd[1] = 16'h0000; drive();
    serve_one(0, 8, m);
    step();
    chk("m1_rdata_A5C3", 32'(m1_rdata), 32'h0000A5C3);
    chk("rw_retained", 32'(rw), 0);

    // Contention: strict alternation
    rq[0] = 1; rq[1] = 1; rand_fields(0); rand_fields(1); drive();
    for (int i = 0; i < 4; i++) begin
      serve_one(i < 3, 8, m);
      chk("alternate", 32'(m), 32'(i % 2));
    end
    serve_one(0, 8, m);
    chk("leftover_m0", 32'(m), 0);

    // Randomized request patterns
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 2; k++)
        if (!rq[k] && $urandom_range(0, 1) == 1) begin rq[k] = 1; rand_fields(k); end
      if (!rq[0] && !rq[1]) begin
        t = int'($urandom_range(0, 1)); rq[t] = 1; rand_fields(t);
      end
      drive();
      serve_one(0, 8, m);
    end
    while (rq[0] || rq[1]) serve_one(0, 8, m);

    // Reset while waiting for ready to return
    rq[0] = 1; r_w[0] = 0; a[0] = AW'($urandom); drive();
    t = 0;
    while (!mem && t < 40) begin step(); t++; end
    chk("rst_op_mem", 32'(mem), 1);
    repeat (3) step();
    chk("rst_op_busy", 32'(ready), 0);
    reset = 1'b1; rq[0] = 0; drive();
    step();
    chk("rst_mid_outputs", {29'd0, mem, rw, m0_ack | m1_ack}, 0);
    chk("rst_mid_addr_data", {address[15:0], data_in}, 0);
    chk("rst_mid_rdata", {m0_rdata, m1_rdata}, 0);
    reset = 1'b0; exp_last = 1; exp_rd[0] = '0; exp_rd[1] = '0;
    mc = mem_cnt; seen_ack = 0;
    repeat (8) begin step(); seen_ack |= (m0_ack | m1_ack); end
    chk("rst_no_ack", 32'(seen_ack), 0);
    chk("rst_no_mem", 32'(mem_cnt - mc), 0);
    rq[1] = 1; rand_fields(1); drive();
    serve_one(0, 8, m);
    chk("post_rst_m1", 32'(m), 1);

    // Not ready: no issue; then ready never drops -> busy timeout
    force_low = 1; rq[0] = 1; r_w[0] = 1; a[0] = AW'($urandom); wd[0] = DW'($urandom); drive();
    mc = mem_cnt; seen_ack = 0;
    repeat (10) begin step(); seen_ack |= (m0_ack | m1_ack); end
    chk("not_ready_no_mem", 32'(mem_cnt - mc), 0);
    chk("not_ready_no_ack", 32'(seen_ack), 0);
    never_drop = 1; force_low = 0;
    serve_one(0, 6, m);
    never_drop = 0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
